dwc_fault_monitor: RTL and testbench
====================================

# dwc_fault_monitor

Downstream consumer of the duplicate-with-comparison state machine (`dwc_SM`). It watches each completed comparison (`interupt_prompt` strobe plus `isMatch` verdict) and keeps match and mismatch statistics. On a mismatch it requests a rollback from the processor. After `MAX_RETRY` consecutive failed retries it escalates to a sticky fatal fault that only software can clear.

## Interface
Parameters:
- `CNT_W`, 16: width of the match and mismatch statistic counters.
- `MAX_RETRY`, 3: consecutive mismatches tolerated before fatal; legal range 0..254.
- `ACK_TIMEOUT`, 1024: cycles to wait for `rollback_ack`; used only with `DWC_MON_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `interupt_prompt`  in  1  comparison-complete strobe from `dwc_SM`; rising edge = one event.
- `isMatch`  in  1  comparison verdict; sampled in the event cycle.
- `rollback_ack`  in  1  processor acknowledges the rollback request.
- `fault_clear`  in  1  software pulse; leaves FATAL and zeroes `consec_mismatch`.
- `counters_clear`  in  1  software pulse; zeroes `match_count` and `mismatch_count`.
- `rollback_req`  out  1  level; held until acknowledged.
- `fatal_fault`  out  1  sticky fatal indication.
- `irq`  out  1  one-cycle pulse on entry to ROLLBACK or FATAL.
- `match_count`  out  `CNT_W`  saturating count of matching events.
- `mismatch_count`  out  `CNT_W`  saturating count of mismatching events.
- `consec_mismatch`  out  8  consecutive mismatches; saturates at 255.
- `state`  out  2  encoding: IDLE=0, ROLLBACK=1, RETRY=2, FATAL=3.

## Operation
Event detection:
- Event = `interupt_prompt & ~prompt_q`, where `prompt_q` is registered `interupt_prompt`.
- A held-high prompt counts once.

Counters:
- Every event increments `match_count` or `mismatch_count`, in any state.
- Counters saturate at all-ones; they never wrap.

State machine:
- IDLE:
  - match event → stay, `consec_mismatch`=0.
  - mismatch event → `consec_mismatch`+1. If the new value > `MAX_RETRY` → FATAL, else → ROLLBACK.
- ROLLBACK:
  - `rollback_req`=1.
  - `rollback_ack` → RETRY.
  - Events here are stale: counted only, no FSM effect.
- RETRY:
  - match event → IDLE, `consec_mismatch`=0.
  - mismatch event → increment, then the same ROLLBACK/FATAL decision as IDLE.
- FATAL:
  - `fatal_fault`=1; events counted only.
  - `fault_clear` → IDLE, `consec_mismatch`=0.
  - `fault_clear` in any other state is ignored.

Outputs and edge cases:
- `irq` pulses for the single cycle after the transition into ROLLBACK or FATAL.
- `MAX_RETRY`=0: the first mismatch goes directly to FATAL; no rollback is ever issued.
- `counters_clear` coincident with an event: clear wins and the event is not counted. FSM and `consec_mismatch` still process the event.
- `rollback_ack` outside ROLLBACK is ignored.
- Reset mid-operation (any state, including an outstanding request) returns immediately to IDLE with all outputs at their reset values.

## Timing
- Reset values: `state`=IDLE, `rollback_req`=0, `fatal_fault`=0, `irq`=0, all counters 0, `prompt_q`=0.
- All outputs are registered.
- Event latency: prompt rises in cycle N → `state`, `rollback_req`, `fatal_fault`, counters, `consec_mismatch` and `irq` update in cycle N+1.
- Ack latency: `rollback_ack` high in cycle M → `rollback_req`=0 and `state`=RETRY in cycle M+1.
- Minimum event spacing: 2 cycles (prompt must fall for at least one cycle between events).

## Configuration
- `DWC_MON_TIMEOUT_EN` defined:
  - An ack-wait counter starts on entry to ROLLBACK.
  - If `rollback_ack` has not arrived after `ACK_TIMEOUT` cycles in ROLLBACK → FATAL, with an `irq` pulse; `consec_mismatch` is unchanged.
  - The counter resets on leaving ROLLBACK.
- `DWC_MON_TIMEOUT_EN` undefined:
  - No timeout logic is built; ROLLBACK waits indefinitely.
  - `ACK_TIMEOUT` is unused.

## Test plan
- Three match events (prompt 1-cycle pulses, `isMatch`=1) → `match_count`=3, `mismatch_count`=0, `state`=IDLE, no `irq`.
- Mismatch, then ack, then a match event → ROLLBACK and `irq` the cycle after the event; `rollback_req` drops one cycle after ack; RETRY→IDLE; `consec_mismatch` returns to 0.
- `MAX_RETRY`=3, four mismatches each followed by ack → `consec_mismatch`=4, `state`=FATAL, `fatal_fault`=1. A `fault_clear` pulse then gives IDLE, `fatal_fault`=0, `mismatch_count`=4.
- Prompt held high for 5 cycles with `isMatch`=1, alongside `counters_clear` asserted on a separate event cycle → single-event counting and clear-wins behaviour both confirmed.
- Reset asserted while in ROLLBACK with `mismatch_count`=2 → all outputs 0 and IDLE asynchronously, before the next clock edge.
- With `DWC_MON_TIMEOUT_EN` and `ACK_TIMEOUT`=8, a mismatch and no ack → FATAL 8 cycles after entering ROLLBACK, with `irq` pulse and `consec_mismatch`=1.

Source files
------------

// File: rtl/dwc_fault_monitor.sv
// dwc_fault_monitor
// Watches completed duplicate-with-comparison events. It keeps saturating
// match/mismatch statistics, requests a processor rollback on a mismatch,
// and escalates to a sticky fatal fault after too many consecutive failures.
//
// Optional build macro: DWC_MON_TIMEOUT_EN
//   defined   -> a ROLLBACK that sees no rollback_ack for ACK_TIMEOUT cycles
//                escalates to FATAL.
//   undefined -> ROLLBACK waits indefinitely; ACK_TIMEOUT has no effect.
module dwc_fault_monitor #(
  parameter int CNT_W       = 16,
  parameter int MAX_RETRY   = 3,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             interupt_prompt,
  input  logic             isMatch,
  input  logic             rollback_ack,
  input  logic             fault_clear,
  input  logic             counters_clear,
  output logic             rollback_req,
  output logic             fatal_fault,
  output logic             irq,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [7:0]       consec_mismatch,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROLLBACK = 2'd1,
    ST_RETRY    = 2'd2,
    ST_FATAL    = 2'd3
  } state_t;

  // Compare in 9 bits so a saturated count of 255 still exceeds MAX_RETRY <= 254.
  localparam logic [8:0] MAX_RETRY_L = 9'(MAX_RETRY);

  state_t           r_state;
  logic             r_prompt_q;
  logic             r_rollback_req;
  logic             r_fatal_fault;
  logic             r_irq;
  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] r_mismatch_count;
  logic [7:0]       r_consec;

  logic             w_event;
  logic [7:0]       w_consec_inc;
  logic             w_over_limit;
  logic             w_timeout;

  // A prompt that stays high counts as a single event.
  assign w_event      = interupt_prompt & ~r_prompt_q;
  assign w_consec_inc = (r_consec == 8'hFF) ? 8'hFF : (r_consec + 8'd1);
  assign w_over_limit = ({1'b0, w_consec_inc} > MAX_RETRY_L);

`ifdef DWC_MON_TIMEOUT_EN
  localparam int ACK_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [ACK_CNT_W-1:0] r_ack_cnt;

  // Count cycles spent in ROLLBACK; zero whenever we are elsewhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack_cnt <= '0;
    end else if (r_state == ST_ROLLBACK) begin
      r_ack_cnt <= r_ack_cnt + ACK_CNT_W'(1);
    end else begin
      r_ack_cnt <= '0;
    end
  end

  // The last allowed ROLLBACK cycle without an ack triggers escalation.
  assign w_timeout = (r_state == ST_ROLLBACK) && !rollback_ack &&
                     (r_ack_cnt == ACK_CNT_W'(ACK_TIMEOUT - 1));
`else
  logic [31:0] w_unused_ack_timeout;
  assign w_unused_ack_timeout = 32'(ACK_TIMEOUT);
  assign w_timeout            = 1'b0;
`endif

  // Delay the prompt by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prompt_q <= 1'b0;
    end else begin
      r_prompt_q <= interupt_prompt;
    end
  end

  // Saturating statistics; a clear overrides a coincident event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_match_count    <= '0;
      r_mismatch_count <= '0;
    end else if (counters_clear) begin
      r_match_count    <= '0;
      r_mismatch_count <= '0;
    end else if (w_event) begin
      if (isMatch) begin
        if (r_match_count != '1) r_match_count <= r_match_count + CNT_W'(1);
      end else begin
        if (r_mismatch_count != '1) r_mismatch_count <= r_mismatch_count + CNT_W'(1);
      end
    end
  end

  // Rollback/retry/fatal state machine with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_rollback_req <= 1'b0;
      r_fatal_fault  <= 1'b0;
      r_irq          <= 1'b0;
      r_consec       <= 8'd0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RETRY: begin
          if (w_event) begin
            if (isMatch) begin
              r_consec <= 8'd0;
              r_state  <= ST_IDLE;
            end else begin
              r_consec <= w_consec_inc;
              r_irq    <= 1'b1;
              if (w_over_limit) begin
                r_state       <= ST_FATAL;
                r_fatal_fault <= 1'b1;
              end else begin
                r_state        <= ST_ROLLBACK;
                r_rollback_req <= 1'b1;
              end
            end
          end
        end
        ST_ROLLBACK: begin
          // Events arriving here are stale and only affect the statistics.
          if (rollback_ack) begin
            r_state        <= ST_RETRY;
            r_rollback_req <= 1'b0;
          end else if (w_timeout) begin
            r_state        <= ST_FATAL;
            r_rollback_req <= 1'b0;
            r_fatal_fault  <= 1'b1;
            r_irq          <= 1'b1;
          end
        end
        ST_FATAL: begin
          if (fault_clear) begin
            r_state       <= ST_IDLE;
            r_fatal_fault <= 1'b0;
            r_consec      <= 8'd0;
          end
        end
      endcase
    end
  end

  assign rollback_req    = r_rollback_req;
  assign fatal_fault     = r_fatal_fault;
  assign irq             = r_irq;
  assign match_count     = r_match_count;
  assign mismatch_count  = r_mismatch_count;
  assign consec_mismatch = r_consec;
  assign state           = r_state;

endmodule

// File: tb/tb_dwc_fault_monitor.sv
// Directed testbench for dwc_fault_monitor (MAX_RETRY=3, ACK_TIMEOUT=8).
module tb_dwc_fault_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        interupt_prompt = 1'b0;
  logic        isMatch = 1'b0;
  logic        rollback_ack = 1'b0;
  logic        fault_clear = 1'b0;
  logic        counters_clear = 1'b0;
  logic        rollback_req;
  logic        fatal_fault;
  logic        irq;
  logic [15:0] match_count;
  logic [15:0] mismatch_count;
  logic [7:0]  consec_mismatch;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dwc_fault_monitor #(
    .CNT_W      (16),
    .MAX_RETRY  (3),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .interupt_prompt(interupt_prompt),
    .isMatch        (isMatch),
    .rollback_ack   (rollback_ack),
    .fault_clear    (fault_clear),
    .counters_clear (counters_clear),
    .rollback_req   (rollback_req),
    .fatal_fault    (fatal_fault),
    .irq            (irq),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .consec_mismatch(consec_mismatch),
    .state          (state)
  );

  // Stimulus helpers: each returns at the negedge of the cycle after the action,
  // where the registered response is visible.
  task automatic do_event(input logic m);
    @(negedge clk);
    interupt_prompt = 1'b1;
    isMatch         = m;
    @(negedge clk);
    interupt_prompt = 1'b0;
    $display("event isMatch=%0b -> state=%0d req=%0b irq=%0b fatal=%0b consec=%0d mc=%0d mmc=%0d",
             m, state, rollback_req, irq, fatal_fault, consec_mismatch, match_count, mismatch_count);
  endtask

  task automatic do_ack();
    @(negedge clk);
    rollback_ack = 1'b1;
    @(negedge clk);
    rollback_ack = 1'b0;
    $display("ack -> state=%0d req=%0b", state, rollback_req);
  endtask

  task automatic do_fault_clear();
    @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    $display("fault_clear -> state=%0d fatal=%0b consec=%0d", state, fatal_fault, consec_mismatch);
  endtask

  task automatic do_counters_clear();
    @(negedge clk);
    counters_clear = 1'b1;
    @(negedge clk);
    counters_clear = 1'b0;
    $display("counters_clear -> mc=%0d mmc=%0d", match_count, mismatch_count);
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_cmp++; if (rollback_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", rollback_req); end
    n_cmp++; if (fatal_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fatal got=%0b exp=0", fatal_fault); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%0b exp=0", irq); end
    n_cmp++; if (match_count !== 16'd0 || mismatch_count !== 16'd0 || consec_mismatch !== 8'd0) begin
      n_fail++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", match_count, mismatch_count, consec_mismatch);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_matches();
    for (int i = 1; i <= 3; i++) begin
      do_event(1'b1);
      n_cmp++; if (match_count !== 16'(i)) begin n_fail++; $display("FAIL match_cnt got=%0d exp=%0d", match_count, i); end
      n_cmp++; if (irq !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL match_idle got irq=%0b state=%0d exp irq=0 state=0", irq, state); end
    end
    n_cmp++; if (mismatch_count !== 16'd0) begin n_fail++; $display("FAIL match_mmc got=%0d exp=0", mismatch_count); end
  endtask

  task automatic test_rollback();
    do_event(1'b0);
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL rb_state got=%0d exp=1", state); end
    n_cmp++; if (irq !== 1'b1 || rollback_req !== 1'b1) begin n_fail++; $display("FAIL rb_irq_req got=%0b/%0b exp=1/1", irq, rollback_req); end
    n_cmp++; if (consec_mismatch !== 8'd1 || mismatch_count !== 16'd1) begin n_fail++; $display("FAIL rb_counts got=%0d/%0d exp=1/1", consec_mismatch, mismatch_count); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0 || rollback_req !== 1'b1) begin n_fail++; $display("FAIL rb_hold got irq=%0b req=%0b exp irq=0 req=1", irq, rollback_req); end
    // stale event during ROLLBACK: counted only
    do_event(1'b1);
    n_cmp++; if (state !== 2'd1 || match_count !== 16'd4) begin n_fail++; $display("FAIL rb_stale got state=%0d mc=%0d exp state=1 mc=4", state, match_count); end
    do_ack();
    n_cmp++; if (state !== 2'd2 || rollback_req !== 1'b0) begin n_fail++; $display("FAIL rb_ack got state=%0d req=%0b exp state=2 req=0", state, rollback_req); end
    do_event(1'b1);
    n_cmp++; if (state !== 2'd0 || consec_mismatch !== 8'd0) begin n_fail++; $display("FAIL rb_recover got state=%0d consec=%0d exp state=0 consec=0", state, consec_mismatch); end
    n_cmp++; if (match_count !== 16'd5) begin n_fail++; $display("FAIL rb_mc got=%0d exp=5", match_count); end
  endtask

  task automatic test_fatal();
    do_counters_clear();
    n_cmp++; if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin n_fail++; $display("FAIL clr got=%0d/%0d exp=0/0", match_count, mismatch_count); end
    for (int i = 1; i <= 3; i++) begin
      do_event(1'b0);
      n_cmp++; if (state !== 2'd1 || consec_mismatch !== 8'(i)) begin n_fail++; $display("FAIL ft_rb%0d got state=%0d consec=%0d exp state=1 consec=%0d", i, state, consec_mismatch, i); end
      do_ack();
    end
    // fault_clear outside FATAL is ignored
    do_fault_clear();
    n_cmp++; if (state !== 2'd2 || consec_mismatch !== 8'd3) begin n_fail++; $display("FAIL ft_clr_ign got state=%0d consec=%0d exp state=2 consec=3", state, consec_mismatch); end
    do_event(1'b0);
    n_cmp++; if (state !== 2'd3 || fatal_fault !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL ft_enter got state=%0d fatal=%0b irq=%0b exp 3/1/1", state, fatal_fault, irq); end
    n_cmp++; if (consec_mismatch !== 8'd4 || rollback_req !== 1'b0) begin n_fail++; $display("FAIL ft_consec got consec=%0d req=%0b exp 4/0", consec_mismatch, rollback_req); end
    do_ack();
    n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL ft_ack_ign got=%0d exp=3", state); end
    do_event(1'b1);
    n_cmp++; if (state !== 2'd3 || match_count !== 16'd1) begin n_fail++; $display("FAIL ft_evt got state=%0d mc=%0d exp 3/1", state, match_count); end
    do_fault_clear();
    n_cmp++; if (state !== 2'd0 || fatal_fault !== 1'b0 || consec_mismatch !== 8'd0) begin n_fail++; $display("FAIL ft_clear got state=%0d fatal=%0b consec=%0d exp 0/0/0", state, fatal_fault, consec_mismatch); end
    n_cmp++; if (mismatch_count !== 16'd4) begin n_fail++; $display("FAIL ft_mmc got=%0d exp=4", mismatch_count); end
  endtask

  task automatic test_held_and_clear();
    do_counters_clear();
    @(negedge clk);
    interupt_prompt = 1'b1;
    isMatch         = 1'b1;
    repeat (5) @(negedge clk);
    interupt_prompt = 1'b0;
    $display("held prompt 5 cycles -> mc=%0d", match_count);
    n_cmp++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL held_mc got=%0d exp=1", match_count); end
    // clear coincident with a mismatch event
    @(negedge clk);
    interupt_prompt = 1'b1;
    isMatch         = 1'b0;
    counters_clear  = 1'b1;
    @(negedge clk);
    interupt_prompt = 1'b0;
    counters_clear  = 1'b0;
    $display("clear+event -> state=%0d mc=%0d mmc=%0d consec=%0d", state, match_count, mismatch_count, consec_mismatch);
    n_cmp++; if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin n_fail++; $display("FAIL clrwin got=%0d/%0d exp=0/0", match_count, mismatch_count); end
    n_cmp++; if (state !== 2'd1 || consec_mismatch !== 8'd1 || irq !== 1'b1) begin n_fail++; $display("FAIL clrwin_fsm got state=%0d consec=%0d irq=%0b exp 1/1/1", state, consec_mismatch, irq); end
    do_ack();
    do_event(1'b1);
  endtask

  task automatic test_back_to_back();
    do_counters_clear();
    do_ack();
    n_cmp++; if (state !== 2'd0) begin n_fail++; $display("FAIL ack_idle got=%0d exp=0", state); end
    do_event(1'b1);
    do_event(1'b0);
    n_cmp++; if (state !== 2'd1 || match_count !== 16'd1 || mismatch_count !== 16'd1) begin
      n_fail++; $display("FAIL b2b got state=%0d mc=%0d mmc=%0d exp 1/1/1", state, match_count, mismatch_count);
    end
  endtask

  task automatic test_async_reset();
    // currently ROLLBACK, consec=1, mismatch_count=1
    do_ack();
    do_event(1'b0);
    n_cmp++; if (state !== 2'd1 || mismatch_count !== 16'd2) begin n_fail++; $display("FAIL ar_pre got state=%0d mmc=%0d exp 1/2", state, mismatch_count); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("async reset mid-cycle -> state=%0d req=%0b mmc=%0d", state, rollback_req, mismatch_count);
    n_cmp++; if (state !== 2'd0 || rollback_req !== 1'b0 || fatal_fault !== 1'b0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL ar_ctl got state=%0d req=%0b fatal=%0b irq=%0b exp 0/0/0/0", state, rollback_req, fatal_fault, irq);
    end
    n_cmp++; if (match_count !== 16'd0 || mismatch_count !== 16'd0 || consec_mismatch !== 8'd0) begin
      n_fail++; $display("FAIL ar_cnt got=%0d/%0d/%0d exp 0/0/0", match_count, mismatch_count, consec_mismatch);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef DWC_MON_TIMEOUT_EN
  task automatic test_timeout();
    do_event(1'b0);
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL to_enter got=%0d exp=1", state); end
    repeat (7) @(negedge clk);
    n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL to_early got=%0d exp=1", state); end
    @(negedge clk);
    $display("timeout -> state=%0d irq=%0b consec=%0d", state, irq, consec_mismatch);
    n_cmp++; if (state !== 2'd3 || fatal_fault !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL to_fatal got state=%0d fatal=%0b irq=%0b exp 3/1/1", state, fatal_fault, irq); end
    n_cmp++; if (consec_mismatch !== 8'd1 || rollback_req !== 1'b0) begin n_fail++; $display("FAIL to_consec got consec=%0d req=%0b exp 1/0", consec_mismatch, rollback_req); end
    do_fault_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_matches();
    test_rollback();
    test_fatal();
    test_held_and_clear();
    test_back_to_back();
    test_async_reset();
`ifdef DWC_MON_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
